// File: rtl/imem_dmem_arbiter.sv
// Arbitrates one single-port synchronous RAM between instruction fetch and load/store.
// Data wins by default, and a streak counter bounds how long a waiting fetch can starve.
module imem_dmem_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] LP_MAX = 4'(MAX_STREAK);

  logic [3:0]      r_streak;
  logic [3:0]      w_streak_nxt;
  logic            w_d_win;
  logic            w_if_win;
  logic            w_tag_vld;
  logic            w_tag_own;
  logic [RD_LAT:1] r_vld_pipe;
  logic [RD_LAT:1] r_own_pipe;

  // Grants are held low while in reset so nothing reaches the RAM.
  always_comb begin
    w_d_win  = 1'b0;
    w_if_win = 1'b0;
    if (rst) begin
      if (d_req && (!if_req || (r_streak < LP_MAX))) w_d_win  = 1'b1;
      else if (if_req)                               w_if_win = 1'b1;
    end
  end

  assign d_gnt  = w_d_win;
  assign if_gnt = w_if_win;

  always_comb begin
    w_streak_nxt = 4'd0;
    if (w_d_win && if_req)
      w_streak_nxt = (r_streak >= LP_MAX) ? LP_MAX : r_streak + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_streak <= 4'd0;
    else      r_streak <= w_streak_nxt;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_addr  = '0;
    mem_we    = 4'b0000;
    mem_wdata = '0;
    if (w_d_win) begin
      mem_en    = 1'b1;
      mem_addr  = d_addr;
      mem_we    = d_we;
      mem_wdata = d_wdata;
    end else if (w_if_win) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end
  end

  // Tag pipeline mirrors the RAM read latency; owner 1 = data port.
  assign w_tag_vld = w_if_win | (w_d_win & (d_we == 4'b0000));
  assign w_tag_own = w_d_win;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_pipe <= '0;
      r_own_pipe <= '0;
    end else begin
      r_vld_pipe[1] <= w_tag_vld;
      r_own_pipe[1] <= w_tag_own;
      for (int i = 2; i <= RD_LAT; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_own_pipe[i] <= r_own_pipe[i-1];
      end
    end
  end

  assign if_rvalid = r_vld_pipe[RD_LAT] & ~r_own_pipe[RD_LAT];
  assign d_rvalid  = r_vld_pipe[RD_LAT] &  r_own_pipe[RD_LAT];
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid  ? mem_rdata : '0;

  // Requesters must hold req and payload stable until granted.
  a_if_hold: assert property (@(posedge clk) disable iff (!rst)
    (if_req && !if_gnt) |=> (if_req && $stable(if_addr)));
  a_d_hold: assert property (@(posedge clk) disable iff (!rst)
    (d_req && !d_gnt) |=> (d_req && $stable(d_addr) && $stable(d_we) && $stable(d_wdata)));
  a_one_gnt: assert property (@(posedge clk) !(if_gnt && d_gnt));

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench: three arbiter instances (RD_LAT 1,2,3) share stimulus and a byte-enable RAM model.
module tb_imem_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req;
  logic [13:0] if_addr, d_addr;
  logic [3:0]  d_we;
  logic [31:0] d_wdata;

  logic [2:0]  if_gnt_a, if_rvalid_a, d_gnt_a, d_rvalid_a, mem_en_a;
  logic [31:0] if_rdata_a [3];
  logic [31:0] d_rdata_a [3];
  logic [13:0] mem_addr_a [3];
  logic [3:0]  mem_we_a [3];
  logic [31:0] mem_wdata_a [3];

  logic [31:0] mem [0:16383];
  logic [31:0] rd_pipe [0:3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(.RD_LAT(1)) dut0 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_a[0]),
    .if_rvalid(if_rvalid_a[0]), .if_rdata(if_rdata_a[0]), .d_req(d_req), .d_addr(d_addr),
    .d_we(d_we), .d_wdata(d_wdata), .d_gnt(d_gnt_a[0]), .d_rvalid(d_rvalid_a[0]),
    .d_rdata(d_rdata_a[0]), .mem_en(mem_en_a[0]), .mem_addr(mem_addr_a[0]),
    .mem_we(mem_we_a[0]), .mem_wdata(mem_wdata_a[0]), .mem_rdata(rd_pipe[0]));

  imem_dmem_arbiter #(.RD_LAT(2)) dut1 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_a[1]),
    .if_rvalid(if_rvalid_a[1]), .if_rdata(if_rdata_a[1]), .d_req(d_req), .d_addr(d_addr),
    .d_we(d_we), .d_wdata(d_wdata), .d_gnt(d_gnt_a[1]), .d_rvalid(d_rvalid_a[1]),
    .d_rdata(d_rdata_a[1]), .mem_en(mem_en_a[1]), .mem_addr(mem_addr_a[1]),
    .mem_we(mem_we_a[1]), .mem_wdata(mem_wdata_a[1]), .mem_rdata(rd_pipe[1]));

  imem_dmem_arbiter #(.RD_LAT(3)) dut2 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_a[2]),
    .if_rvalid(if_rvalid_a[2]), .if_rdata(if_rdata_a[2]), .d_req(d_req), .d_addr(d_addr),
    .d_we(d_we), .d_wdata(d_wdata), .d_gnt(d_gnt_a[2]), .d_rvalid(d_rvalid_a[2]),
    .d_rdata(d_rdata_a[2]), .mem_en(mem_en_a[2]), .mem_addr(mem_addr_a[2]),
    .mem_we(mem_we_a[2]), .mem_wdata(mem_wdata_a[2]), .mem_rdata(rd_pipe[2]));

  // RAM model driven by instance 0; all instances see identical grants.
  initial for (int i = 0; i < 16384; i++) mem[i] = i;

  always @(posedge clk) begin
    if (mem_en_a[0] && mem_we_a[0] != 4'b0000)
      for (int b = 0; b < 4; b++)
        if (mem_we_a[0][b]) mem[mem_addr_a[0]][8*b +: 8] = mem_wdata_a[0][8*b +: 8];
    rd_pipe[3] <= rd_pipe[2];
    rd_pipe[2] <= rd_pipe[1];
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[0] <= (mem_en_a[0] && mem_we_a[0] == 4'b0000) ? mem[mem_addr_a[0]] : 32'h0;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; if_req = 1'b1; d_req = 1'b1; if_addr = 14'h155; d_addr = 14'h2AA;
    d_we = 4'hF; d_wdata = 32'hA5A5A5A5;
    #1;
    n_tests++; if (if_gnt_a !== 3'b000) begin n_fail++; $display("FAIL rst_if_gnt got %b exp 000", if_gnt_a); end
    n_tests++; if (d_gnt_a !== 3'b000) begin n_fail++; $display("FAIL rst_d_gnt got %b exp 000", d_gnt_a); end
    n_tests++; if (mem_en_a !== 3'b000) begin n_fail++; $display("FAIL rst_mem_en got %b exp 000", mem_en_a); end
    n_tests++; if (mem_we_a[0] !== 4'h0) begin n_fail++; $display("FAIL rst_mem_we got %h exp 0", mem_we_a[0]); end
    n_tests++; if (mem_addr_a[0] !== 14'h0) begin n_fail++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr_a[0]); end
    n_tests++; if (mem_wdata_a[0] !== 32'h0) begin n_fail++; $display("FAIL rst_mem_wdata got %h exp 0", mem_wdata_a[0]); end
    n_tests++; if ((if_rvalid_a | d_rvalid_a) !== 3'b000) begin n_fail++; $display("FAIL rst_rvalid got %b exp 000", if_rvalid_a | d_rvalid_a); end
    n_tests++; if ((if_rdata_a[0] | d_rdata_a[0]) !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h exp 0", if_rdata_a[0] | d_rdata_a[0]); end
    n_tests++; if (dut0.r_streak !== 4'd0) begin n_fail++; $display("FAIL rst_streak got %0d exp 0", dut0.r_streak); end
    if_req = 1'b0; d_req = 1'b0; d_we = 4'h0; d_wdata = 32'h0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_fetch_only();
    for (int i = 0; i < 4; i++) begin
      if_req  = (i < 3);
      if_addr = 14'h010 + 14'(i);
      #1;
      n_tests++; if (if_gnt_a[0] !== (i < 3)) begin n_fail++; $display("FAIL fetch_gnt[%0d] got %b exp %b", i, if_gnt_a[0], (i < 3)); end
      if (i < 3) begin
        n_tests++; if (mem_addr_a[0] !== 14'h010 + 14'(i) || mem_we_a[0] !== 4'h0 || mem_en_a[0] !== 1'b1)
          begin n_fail++; $display("FAIL fetch_mem[%0d] got en=%b addr=%h we=%h", i, mem_en_a[0], mem_addr_a[0], mem_we_a[0]); end
      end
      n_tests++; if (if_rvalid_a[0] !== (i > 0)) begin n_fail++; $display("FAIL fetch_rvalid[%0d] got %b exp %b", i, if_rvalid_a[0], (i > 0)); end
      n_tests++; if (if_rdata_a[0] !== ((i > 0) ? 32'h0000000F + 32'(i) : 32'h0))
        begin n_fail++; $display("FAIL fetch_rdata[%0d] got %h exp %h", i, if_rdata_a[0], (i > 0) ? 32'h0000000F + 32'(i) : 32'h0); end
      n_tests++; if (d_rvalid_a[0] !== 1'b0) begin n_fail++; $display("FAIL fetch_d_rvalid[%0d] got %b exp 0", i, d_rvalid_a[0]); end
      step();
    end
    #1;
    n_tests++; if (if_rvalid_a[0] !== 1'b0) begin n_fail++; $display("FAIL fetch_rvalid_end got %b exp 0", if_rvalid_a[0]); end
    step(); step();
  endtask

  task automatic test_store_load();
    logic        req [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0]  we  [4] = '{4'hF, 4'h3, 4'h0, 4'h0};
    logic [31:0] wd  [4] = '{32'hDEADBEEF, 32'h00001234, 32'h0, 32'h0};
    logic        erv [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] erd [4] = '{32'h0, 32'h0, 32'h0, 32'hDEAD1234};
    for (int i = 0; i < 4; i++) begin
      d_req = req[i]; d_addr = 14'h020; d_we = we[i]; d_wdata = wd[i];
      #1;
      n_tests++; if (d_gnt_a[0] !== req[i]) begin n_fail++; $display("FAIL sl_gnt[%0d] got %b exp %b", i, d_gnt_a[0], req[i]); end
      n_tests++; if (mem_we_a[0] !== we[i] || mem_wdata_a[0] !== wd[i])
        begin n_fail++; $display("FAIL sl_mem[%0d] got we=%h wd=%h exp we=%h wd=%h", i, mem_we_a[0], mem_wdata_a[0], we[i], wd[i]); end
      n_tests++; if (d_rvalid_a[0] !== erv[i]) begin n_fail++; $display("FAIL sl_rvalid[%0d] got %b exp %b", i, d_rvalid_a[0], erv[i]); end
      n_tests++; if (d_rdata_a[0] !== erd[i]) begin n_fail++; $display("FAIL sl_rdata[%0d] got %h exp %h", i, d_rdata_a[0], erd[i]); end
      step();
    end
    #1;
    n_tests++; if (d_rvalid_a[0] !== 1'b0) begin n_fail++; $display("FAIL sl_rvalid_end got %b exp 0", d_rvalid_a[0]); end
    step(); step();
  endtask

  task automatic test_starvation();
    logic       exp_d [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] exp_s [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};
    if_req = 1'b1; if_addr = 14'h050; d_req = 1'b1; d_addr = 14'h060; d_we = 4'h0; d_wdata = 32'h0;
    for (int i = 0; i < 12; i++) begin
      #1;
      n_tests++; if (dut0.r_streak !== exp_s[i]) begin n_fail++; $display("FAIL starve_streak[%0d] got %0d exp %0d", i, dut0.r_streak, exp_s[i]); end
      n_tests++; if (d_gnt_a[0] !== exp_d[i] || if_gnt_a[0] !== !exp_d[i])
        begin n_fail++; $display("FAIL starve_gnt[%0d] got d=%b f=%b exp d=%b", i, d_gnt_a[0], if_gnt_a[0], exp_d[i]); end
      if (i > 0) begin
        n_tests++; if (d_rvalid_a[0] !== exp_d[i-1] || if_rvalid_a[0] !== !exp_d[i-1])
          begin n_fail++; $display("FAIL starve_route[%0d] got d=%b f=%b exp d=%b", i, d_rvalid_a[0], if_rvalid_a[0], exp_d[i-1]); end
        n_tests++; if ((d_rdata_a[0] | if_rdata_a[0]) !== (exp_d[i-1] ? 32'h60 : 32'h50))
          begin n_fail++; $display("FAIL starve_rdata[%0d] got %h exp %h", i, d_rdata_a[0] | if_rdata_a[0], exp_d[i-1] ? 32'h60 : 32'h50); end
      end
      step();
    end
    d_req = 1'b0;
    #1;
    n_tests++; if (if_gnt_a[0] !== 1'b1) begin n_fail++; $display("FAIL starve_tail_gnt got %b exp 1", if_gnt_a[0]); end
    step();
    if_req = 1'b0;
    step(); step(); step(); step();
  endtask

  task automatic test_contention();
    logic rq_d [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic rq_f [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic e_dv [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic e_fv [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    d_addr = 14'h030; if_addr = 14'h040; d_we = 4'h0;
    for (int i = 0; i < 8; i++) begin
      d_req = rq_d[i]; if_req = rq_f[i];
      #1;
      n_tests++; if (d_gnt_a[2] !== rq_d[i] || if_gnt_a[2] !== rq_f[i])
        begin n_fail++; $display("FAIL cont_gnt[%0d] got d=%b f=%b exp d=%b f=%b", i, d_gnt_a[2], if_gnt_a[2], rq_d[i], rq_f[i]); end
      n_tests++; if (d_rvalid_a[2] !== e_dv[i] || if_rvalid_a[2] !== e_fv[i])
        begin n_fail++; $display("FAIL cont_rvalid[%0d] got d=%b f=%b exp d=%b f=%b", i, d_rvalid_a[2], if_rvalid_a[2], e_dv[i], e_fv[i]); end
      n_tests++; if (d_rdata_a[2] !== (e_dv[i] ? 32'h30 : 32'h0) || if_rdata_a[2] !== (e_fv[i] ? 32'h40 : 32'h0))
        begin n_fail++; $display("FAIL cont_rdata[%0d] got d=%h f=%h", i, d_rdata_a[2], if_rdata_a[2]); end
      step();
    end
  endtask

  task automatic test_reset_midflight();
    d_req = 1'b1; d_addr = 14'h030; d_we = 4'h0; if_req = 1'b0;
    #1;
    n_tests++; if (d_gnt_a[1] !== 1'b1) begin n_fail++; $display("FAIL mid_gnt got %b exp 1", d_gnt_a[1]); end
    step();
    d_req = 1'b0; rst = 1'b0;
    #1;
    n_tests++; if ({d_rvalid_a[1], if_rvalid_a[1], d_gnt_a[1], if_gnt_a[1], mem_en_a[1]} !== 5'b0)
      begin n_fail++; $display("FAIL mid_rst_ctl got %b exp 00000", {d_rvalid_a[1], if_rvalid_a[1], d_gnt_a[1], if_gnt_a[1], mem_en_a[1]}); end
    n_tests++; if ((d_rdata_a[1] | if_rdata_a[1]) !== 32'h0 || mem_addr_a[1] !== 14'h0 || mem_we_a[1] !== 4'h0)
      begin n_fail++; $display("FAIL mid_rst_data got rd=%h addr=%h we=%h", d_rdata_a[1] | if_rdata_a[1], mem_addr_a[1], mem_we_a[1]); end
    step();
    rst = 1'b1;
    #1;
    n_tests++; if (d_rvalid_a[1] !== 1'b0 || d_rdata_a[1] !== 32'h0)
      begin n_fail++; $display("FAIL mid_lat_slot got v=%b d=%h exp 0", d_rvalid_a[1], d_rdata_a[1]); end
    step();
    #1;
    n_tests++; if (d_rvalid_a[1] !== 1'b0) begin n_fail++; $display("FAIL mid_after got %b exp 0", d_rvalid_a[1]); end
    n_tests++; if (dut1.r_streak !== 4'd0) begin n_fail++; $display("FAIL mid_streak got %0d exp 0", dut1.r_streak); end
    step();
  endtask

  task automatic test_idle();
    if_req = 1'b0; d_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_tests++; if (mem_en_a !== 3'b000 || mem_we_a[0] !== 4'h0)
        begin n_fail++; $display("FAIL idle_mem[%0d] got en=%b we=%h exp 0", i, mem_en_a, mem_we_a[0]); end
      n_tests++; if ((if_gnt_a | d_gnt_a | if_rvalid_a | d_rvalid_a) !== 3'b000)
        begin n_fail++; $display("FAIL idle_act[%0d] got %b exp 000", i, if_gnt_a | d_gnt_a | if_rvalid_a | d_rvalid_a); end
      step();
    end
  endtask

  initial begin
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; if_addr = '0; d_addr = '0; d_we = '0; d_wdata = '0;
    @(negedge clk);
    test_reset();
    test_fetch_only();
    test_store_load();
    test_starvation();
    test_contention();
    test_reset_midflight();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
